// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: address-width helper,
// default-configuration slice types and the hardwired-zero register index.
package rf_pkg;

    localparam int unsigned ZERO_ADDR = 0;

    // Never returns 0, so a degenerate SIZE still yields a legal vector width.
    function automatic int unsigned rf_addr_width(input int unsigned size);
        return (size <= 2) ? 1 : $clog2(size);
    endfunction

    typedef logic [15:0] rf_word_t;
    typedef logic [2:0]  rf_addr_t;

endpackage

// File: rtl/vDFFER.sv
// Enabled D flip-flop bank with asynchronous active-high clear to zero.
module vDFFER #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with fixed write priority, optional zero register,
// optional write-to-read bypass and a per-register busy scoreboard.
module regfile_mp
    import rf_pkg::*;
#(
    parameter  int unsigned WIDTH      = 16,
    parameter  int unsigned SIZE       = 8,
    parameter  int unsigned NR         = 2,
    parameter  int unsigned NW         = 1,
    parameter  int unsigned ZERO_REG   = 0,
    parameter  int unsigned BYPASS     = 1,
    localparam int unsigned ADDR_WIDTH = rf_addr_width(SIZE)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NW-1:0]            wr_en,
    input  logic [NW*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NW*WIDTH-1:0]      wr_data,
    input  logic [NR*ADDR_WIDTH-1:0] rd_addr,
    output logic [NR*WIDTH-1:0]      rd_data,
    output logic [NR-1:0]            rd_busy,
    input  logic                     issue_en,
    input  logic [ADDR_WIDTH-1:0]    issue_addr,
    output logic [SIZE-1:0]          busy_vec
);

    logic [SIZE-1:0]       wr_hit;
    logic [SIZE-1:0]       reg_we;
    logic [SIZE-1:0]       issue_hit;
    logic [SIZE-1:0]       busy_d;
    logic [SIZE-1:0]       busy_q;
    logic [WIDTH-1:0]      reg_wd [SIZE];
    logic [WIDTH-1:0]      regs_q [SIZE];
    logic [ADDR_WIDTH-1:0] rd_idx;

    // Ascending scan lets the highest-index matching port overwrite lower ones.
    // Writes seen while reset is high are discarded, which also blanks bypass.
    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < SIZE; r++) begin
            reg_wd[r] = '0;
            for (int k = 0; k < NW; k++) begin
                if (wr_en[k] && (wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))) begin
                    wr_hit[r] = 1'b1;
                    reg_wd[r] = wr_data[k*WIDTH +: WIDTH];
                end
            end
        end
        wr_hit = wr_hit & {SIZE{~reset}};
    end

    // Issue beats a same-cycle write: the newly issued producer is younger.
    always_comb begin
        reg_we    = wr_hit;
        issue_hit = '0;
        for (int r = 0; r < SIZE; r++) begin
            issue_hit[r] = issue_en && (issue_addr == ADDR_WIDTH'(r));
        end
        busy_d = (busy_q & ~wr_hit) | issue_hit;
        if (ZERO_REG != 0) begin
            reg_we[ZERO_ADDR] = 1'b0;
            busy_d[ZERO_ADDR] = 1'b0;
        end
    end

    for (genvar r = 0; r < SIZE; r++) begin : g_reg
        vDFFER #(.WIDTH(WIDTH)) u_reg (
            .clk_i (clk),
            .rst_i (reset),
            .en_i  (reg_we[r]),
            .d_i   (reg_wd[r]),
            .q_o   (regs_q[r])
        );
    end

    vDFFER #(.WIDTH(SIZE)) u_busy (
        .clk_i (clk),
        .rst_i (reset),
        .en_i  (1'b1),
        .d_i   (busy_d),
        .q_o   (busy_q)
    );

    assign busy_vec = busy_q;

    // Zero-register override is applied last so it also masks bypassed data.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rd_idx  = '0;
        for (int j = 0; j < NR; j++) begin
            rd_idx                    = rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
            rd_data[j*WIDTH +: WIDTH] = regs_q[rd_idx];
            rd_busy[j]                = busy_q[rd_idx];
            if ((BYPASS != 0) && wr_hit[rd_idx]) begin
                rd_data[j*WIDTH +: WIDTH] = reg_wd[rd_idx];
                rd_busy[j]                = 1'b0;
            end
            if ((ZERO_REG != 0) && (rd_idx == ADDR_WIDTH'(ZERO_ADDR))) begin
                rd_data[j*WIDTH +: WIDTH] = '0;
                rd_busy[j]                = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed checks on three 2W/2R variants plus a 3W/4R sweep against a small model.
module tb_regfile_mp;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Shared stimulus for the 2W/2R instances.
    logic [1:0]  wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [5:0]  rd_addr;
    logic        issue_en;
    logic [2:0]  issue_addr;

    logic [31:0] rd_data_m,  rd_data_nb,  rd_data_nz;
    logic [1:0]  rd_busy_m,  rd_busy_nb,  rd_busy_nz;
    logic [7:0]  busy_vec_m, busy_vec_nb, busy_vec_nz;

    // 3W/4R sweep instance.
    logic [2:0]  wr_en_w;
    logic [8:0]  wr_addr_w;
    logic [47:0] wr_data_w;
    logic [11:0] rd_addr_w;
    logic        issue_en_w;
    logic [2:0]  issue_addr_w;
    logic [63:0] rd_data_w;
    logic [3:0]  rd_busy_w;
    logic [7:0]  busy_vec_w;

    regfile_mp #(.WIDTH(16), .SIZE(8), .NR(2), .NW(2), .ZERO_REG(1), .BYPASS(1)) u_main (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_m), .rd_busy(rd_busy_m),
        .issue_en(issue_en), .issue_addr(issue_addr), .busy_vec(busy_vec_m));

    regfile_mp #(.WIDTH(16), .SIZE(8), .NR(2), .NW(2), .ZERO_REG(1), .BYPASS(0)) u_nobyp (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .issue_en(issue_en), .issue_addr(issue_addr), .busy_vec(busy_vec_nb));

    regfile_mp #(.WIDTH(16), .SIZE(8), .NR(2), .NW(2), .ZERO_REG(0), .BYPASS(1)) u_nozero (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_nz), .rd_busy(rd_busy_nz),
        .issue_en(issue_en), .issue_addr(issue_addr), .busy_vec(busy_vec_nz));

    regfile_mp #(.WIDTH(16), .SIZE(8), .NR(4), .NW(3), .ZERO_REG(1), .BYPASS(1)) u_wide (
        .clk(clk), .reset(reset), .wr_en(wr_en_w), .wr_addr(wr_addr_w), .wr_data(wr_data_w),
        .rd_addr(rd_addr_w), .rd_data(rd_data_w), .rd_busy(rd_busy_w),
        .issue_en(issue_en_w), .issue_addr(issue_addr_w), .busy_vec(busy_vec_w));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock, then move 2 ns past the edge before driving.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    rf_word_t    mdl_mem [8];
    logic [7:0]  mdl_busy;
    logic [7:0]  busy_nxt;
    logic [63:0] exp_rd;
    logic [3:0]  exp_rb;
    rf_addr_t    a;
    rf_word_t    d;
    logic        b;
    logic        found;

    initial begin
        reset = 1'b1;
        wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0; issue_en = 1'b0; issue_addr = '0;
        wr_en_w = '0; wr_addr_w = '0; wr_data_w = '0; rd_addr_w = '0; issue_en_w = 1'b0; issue_addr_w = '0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Populate r1, r6 and mark r2 busy, then reset mid-cycle.
        wr_en = 2'b11; wr_addr = {3'd6, 3'd1}; wr_data = {16'h5678, 16'h1234};
        issue_en = 1'b1; issue_addr = 3'd2;
        next_cycle();
        wr_en = '0; issue_en = 1'b0; rd_addr = {3'd6, 3'd1};
        #1;
        check_val("pre_rst_rd",   rd_data_m,  32'h5678_1234);
        check_val("pre_rst_busy", busy_vec_m, 8'h04);

        reset = 1'b1;
        wr_en = 2'b01; wr_addr = {3'd0, 3'd3}; wr_data = {16'h0000, 16'hBEEF};
        rd_addr = {3'd6, 3'd3};
        #1;
        check_val("rst_rd_zero",  rd_data_m,  32'h0);
        check_val("rst_busy_vec", busy_vec_m, 8'h00);
        check_val("rst_rd_busy",  rd_busy_m,  2'b00);
        next_cycle();
        reset = 1'b0; wr_en = '0; rd_addr = {3'd1, 3'd3};
        next_cycle();
        check_val("rst_r3_r1", rd_data_m, 32'h0);

        // Write priority: port 1 beats port 0 on r5.
        wr_en = 2'b11; wr_addr = {3'd5, 3'd5}; wr_data = {16'h2222, 16'h1111};
        rd_addr = {3'd0, 3'd5};
        #1;
        check_val("prio_bypass",     rd_data_m[15:0],  16'h2222);
        check_val("prio_nobyp_pre",  rd_data_nb[15:0], 16'h0000);
        next_cycle();
        wr_en = '0;
        #1;
        check_val("prio_main",  rd_data_m[15:0],  16'h2222);
        check_val("prio_nobyp", rd_data_nb[15:0], 16'h2222);

        // Bypass: r2 = 00AA and busy, then same-cycle write of 0055.
        wr_en = 2'b01; wr_addr = {3'd0, 3'd2}; wr_data = {16'h0, 16'h00AA};
        issue_en = 1'b1; issue_addr = 3'd2;
        next_cycle();
        wr_en = '0; issue_en = 1'b0; rd_addr = {3'd0, 3'd2};
        #1;
        check_val("byp_setup_busy", busy_vec_m,      8'h04);
        check_val("byp_setup_data", rd_data_m[15:0], 16'h00AA);
        check_val("byp_setup_rb",   rd_busy_m[0],    1'b1);
        wr_en = 2'b01; wr_data = {16'h0, 16'h0055};
        #1;
        check_val("byp_data",      rd_data_m[15:0],  16'h0055);
        check_val("byp_rb",        rd_busy_m[0],     1'b0);
        check_val("nobyp_data",    rd_data_nb[15:0], 16'h00AA);
        check_val("nobyp_rb",      rd_busy_nb[0],    1'b1);
        next_cycle();
        wr_en = '0;
        #1;
        check_val("nobyp_after",   rd_data_nb[15:0], 16'h0055);
        check_val("byp_busy_clr",  busy_vec_m,       8'h00);

        // Zero register: write FFFF and issue r0.
        wr_en = 2'b01; wr_addr = {3'd0, 3'd0}; wr_data = {16'h0, 16'hFFFF};
        issue_en = 1'b1; issue_addr = 3'd0; rd_addr = {3'd0, 3'd0};
        #1;
        check_val("zr_rd_pre",  rd_data_m,        32'h0);
        check_val("zr_rb_pre",  rd_busy_m,        2'b00);
        check_val("nz_rd_pre",  rd_data_nz[15:0], 16'hFFFF);
        next_cycle();
        wr_en = '0; issue_en = 1'b0;
        #1;
        check_val("zr_rd",      rd_data_m,        32'h0);
        check_val("zr_busy",    busy_vec_m,       8'h00);
        check_val("nz_rd",      rd_data_nz[15:0], 16'hFFFF);
        check_val("nz_busy",    busy_vec_nz,      8'h01);
        check_val("nz_rb",      rd_busy_nz[0],    1'b1);

        // Scoreboard on r4.
        issue_en = 1'b1; issue_addr = 3'd4; rd_addr = {3'd4, 3'd0};
        #1;
        check_val("sb_issue_same", rd_busy_m[1], 1'b0);
        next_cycle();
        issue_en = 1'b0;
        #1;
        check_val("sb_issue_vec", busy_vec_m,   8'h10);
        check_val("sb_issue_rb",  rd_busy_m[1], 1'b1);
        wr_en = 2'b10; wr_addr = {3'd4, 3'd0}; wr_data = {16'h4444, 16'h0};
        #1;
        check_val("sb_wr_byp_rb",   rd_busy_m[1],     1'b0);
        check_val("sb_wr_byp_data", rd_data_m[31:16], 16'h4444);
        check_val("sb_wr_nobyp_rb", rd_busy_nb[1],    1'b1);
        next_cycle();
        wr_en = '0;
        #1;
        check_val("sb_wr_vec",    busy_vec_m,  8'h00);
        check_val("sb_wr_vec_nb", busy_vec_nb, 8'h00);
        wr_en = 2'b01; wr_addr = {3'd0, 3'd4}; wr_data = {16'h0, 16'h4A4A};
        issue_en = 1'b1; issue_addr = 3'd4;
        next_cycle();
        wr_en = '0; issue_en = 1'b0;
        #1;
        check_val("sb_both_vec",  busy_vec_m,       8'h10);
        check_val("sb_both_data", rd_data_m[31:16], 16'h4A4A);
        check_val("sb_both_rb",   rd_busy_m[1],     1'b1);
        issue_en = 1'b1; issue_addr = 3'd4;
        next_cycle();
        issue_en = 1'b0;
        #1;
        check_val("sb_reissue", busy_vec_m, 8'h10);

        // 3W/4R sweep; the wide instance has seen only resets so far.
        for (int r = 0; r < 8; r++) mdl_mem[r] = '0;
        mdl_busy = '0;
        for (int i = 0; i < 1000; i++) begin
            next_cycle();
            wr_en_w      = 3'($urandom);
            wr_addr_w    = 9'($urandom);
            wr_data_w    = {16'($urandom), 16'($urandom), 16'($urandom)};
            rd_addr_w    = 12'($urandom);
            issue_en_w   = 1'($urandom);
            issue_addr_w = 3'($urandom);
            #1;
            exp_rd = '0;
            exp_rb = '0;
            for (int j = 0; j < 4; j++) begin
                a = rd_addr_w[j*3 +: 3];
                d = mdl_mem[a];
                b = mdl_busy[a];
                found = 1'b0;
                for (int k = 2; k >= 0; k--) begin
                    if (!found && wr_en_w[k] && (wr_addr_w[k*3 +: 3] == a)) begin
                        found = 1'b1;
                        d = wr_data_w[k*16 +: 16];
                        b = 1'b0;
                    end
                end
                if (a == 3'd0) begin
                    d = '0;
                    b = 1'b0;
                end
                exp_rd[j*16 +: 16] = d;
                exp_rb[j]          = b;
            end
            check_val("sweep_rd_data",  rd_data_w,  exp_rd);
            check_val("sweep_rd_busy",  rd_busy_w,  exp_rb);
            check_val("sweep_busy_vec", busy_vec_w, mdl_busy);

            busy_nxt = mdl_busy;
            for (int k = 0; k < 3; k++) begin
                if (wr_en_w[k]) begin
                    busy_nxt[wr_addr_w[k*3 +: 3]] = 1'b0;
                    if (wr_addr_w[k*3 +: 3] != 3'd0) mdl_mem[wr_addr_w[k*3 +: 3]] = wr_data_w[k*16 +: 16];
                end
            end
            if (issue_en_w) busy_nxt[issue_addr_w] = 1'b1;
            busy_nxt[0] = 1'b0;
            mdl_busy = busy_nxt;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
